aos_softreg_responder: RTL and testbench



---
 rtl/aos_softreg_responder.sv | 126 ++++++++++++
 tb/tb_aos_softreg_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/aos_softreg_responder.sv
// App-side SoftReg endpoint: host-visible 64-bit register bank with hardware update ports and a fixed-latency read path.
// Optional AOS_SR_RESP_ERRCNT_EN adds a saturating dropped-access counter readable at idx 127.
module aos_softreg_responder #(
  parameter int           NUM_REGS = 16,
  parameter logic [127:0] RO_MASK  = 128'h0,
  parameter logic [63:0]  OOR_DATA = 64'hDEAD_DEAD_DEAD_DEAD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sr_req_valid_i,
  input  logic                     sr_req_is_write_i,
  input  logic [15:0]              sr_req_addr_i,
  input  logic [63:0]              sr_req_data_i,
  output logic                     sr_resp_valid_o,
  output logic [63:0]              sr_resp_data_o,
  output logic [64*NUM_REGS-1:0]   reg_q_o,
  output logic [NUM_REGS-1:0]      wr_pulse_o,
  input  logic                     hw_wr_en_i,
  input  logic [6:0]               hw_wr_idx_i,
  input  logic [63:0]              hw_wr_data_i
);

  localparam logic [7:0] NREGS_L = 8'(NUM_REGS);

  logic [63:0]         regs_q [NUM_REGS];
  logic [63:0]         regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;

  logic [6:0]  idx;
  logic        in_range, cnt_hit, oor;
  logic        host_wr, host_rd, host_wr_ok;
  logic [63:0] rd_reg, rd_mux;

  logic        vld_p1_q, vld_p2_q;
  logic [63:0] data_p1_q, data_p2_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{sr_req_addr_i[15:10], sr_req_addr_i[2:0]};

  assign idx        = sr_req_addr_i[9:3];
  assign in_range   = {1'b0, idx} < NREGS_L;
  assign oor        = !in_range && !cnt_hit;
  assign host_wr    = sr_req_valid_i && sr_req_is_write_i;
  assign host_rd    = sr_req_valid_i && !sr_req_is_write_i;
  assign host_wr_ok = host_wr && in_range && !RO_MASK[idx];

`ifdef AOS_SR_RESP_ERRCNT_EN
  logic [31:0] errcnt_q, errcnt_d;
  logic        dropped;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign cnt_hit = (idx == 7'd127);
  assign dropped = (sr_req_valid_i && oor) || (host_wr && in_range && RO_MASK[idx]);

  always_comb begin
    errcnt_d = errcnt_q;
    if (host_wr && cnt_hit) errcnt_d = '0;
    else if (dropped)       errcnt_d = sat_inc(errcnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) errcnt_q <= '0;
    else     errcnt_q <= errcnt_d;
  end

  assign rd_mux = oor ? OOR_DATA : (cnt_hit ? {32'b0, errcnt_q} : rd_reg);
`else
  assign cnt_hit = 1'b0;
  assign rd_mux  = oor ? OOR_DATA : rd_reg;
`endif

  // Host write takes priority over a same-index hardware write.
  always_comb begin
    rd_reg = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i]     = regs_q[i];
      wr_pulse_d[i] = 1'b0;
      if (hw_wr_en_i && hw_wr_idx_i == 7'(i)) regs_d[i] = hw_wr_data_i;
      if (host_wr_ok && idx == 7'(i)) begin
        regs_d[i]     = sr_req_data_i;
        wr_pulse_d[i] = 1'b1;
      end
      if (idx == 7'(i)) rd_reg = regs_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      wr_pulse_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      wr_pulse_q <= wr_pulse_d;
    end
  end

  // Stage 1: capture pre-update read data
  always_ff @(posedge clk) begin
    if (host_rd) data_p1_q <= rd_mux;
  end

  // Stage 2: response register, data held while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      data_p2_q <= '0;
    end else begin
      vld_p1_q <= host_rd;
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) data_p2_q <= data_p1_q;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regq
    assign reg_q_o[64*g +: 64] = regs_q[g];
  end

  assign wr_pulse_o      = wr_pulse_q;
  assign sr_resp_valid_o = vld_p2_q;
  assign sr_resp_data_o  = data_p2_q;

endmodule

// File: tb/tb_aos_softreg_responder.sv
// Directed scoreboard bench for aos_softreg_responder (NUM_REGS=16, register 2 read-only).
module tb_aos_softreg_responder;

  localparam int           N   = 16;
  localparam logic [127:0] RO  = 128'h4;
  localparam logic [63:0]  OOR = 64'hDEAD_DEAD_DEAD_DEAD;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            sr_req_valid_i, sr_req_is_write_i;
  logic [15:0]     sr_req_addr_i;
  logic [63:0]     sr_req_data_i;
  logic            sr_resp_valid_o;
  logic [63:0]     sr_resp_data_o;
  logic [64*N-1:0] reg_q_o;
  logic [N-1:0]    wr_pulse_o;
  logic            hw_wr_en_i;
  logic [6:0]      hw_wr_idx_i;
  logic [63:0]     hw_wr_data_i;

  aos_softreg_responder #(.NUM_REGS(N), .RO_MASK(RO), .OOR_DATA(OOR)) dut (
    .clk(clk), .rst(rst),
    .sr_req_valid_i(sr_req_valid_i), .sr_req_is_write_i(sr_req_is_write_i),
    .sr_req_addr_i(sr_req_addr_i), .sr_req_data_i(sr_req_data_i),
    .sr_resp_valid_o(sr_resp_valid_o), .sr_resp_data_o(sr_resp_data_o),
    .reg_q_o(reg_q_o), .wr_pulse_o(wr_pulse_o),
    .hw_wr_en_i(hw_wr_en_i), .hw_wr_idx_i(hw_wr_idx_i), .hw_wr_data_i(hw_wr_data_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        got;
  logic [63:0] m [N];
  logic [31:0] m_err;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] a(input logic [6:0] i);
    return {6'b0, i, 3'b0};
  endfunction

  function automatic logic [63:0] model_rd(input logic [6:0] i);
    if (i < 7'(N)) return m[i[3:0]];
`ifdef AOS_SR_RESP_ERRCNT_EN
    if (i == 7'd127) return {32'b0, m_err};
`endif
    return OOR;
  endfunction

  // Response monitor: every valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (sr_resp_valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp_valid", {63'b0, sr_resp_valid_o}, 64'd0);
      end else begin
        got = sb.pop_front();
        chk("resp_data", sr_resp_data_o, got.data);
        chk("resp_cycle", 64'(cyc), 64'(got.cyc));
      end
    end
  end

  task automatic idle_inputs();
    sr_req_valid_i    = 1'b0;
    sr_req_is_write_i = 1'b0;
    sr_req_addr_i     = '0;
    sr_req_data_i     = '0;
    hw_wr_en_i        = 1'b0;
    hw_wr_idx_i       = '0;
    hw_wr_data_i      = '0;
  endtask

  task automatic check_regs();
    for (int i = 0; i < N; i++)
      chk($sformatf("reg_q[%0d]", i), reg_q_o[64*i +: 64], m[i]);
  endtask

  task automatic step(input logic rv, input logic rw, input logic [15:0] addr,
                      input logic [63:0] d, input logic hen, input logic [6:0] hidx,
                      input logic [63:0] hd);
    logic [6:0]   idx;
    logic [N-1:0] ep;
    logic         drop;
    exp_t         e;
    idx  = addr[9:3];
    ep   = '0;
    drop = 1'b0;
    sr_req_valid_i    = rv;
    sr_req_is_write_i = rw;
    sr_req_addr_i     = addr;
    sr_req_data_i     = d;
    hw_wr_en_i        = hen;
    hw_wr_idx_i       = hidx;
    hw_wr_data_i      = hd;
    if (rv && !rw) begin
      e.data = model_rd(idx);
      e.cyc  = cyc + 2;
      sb.push_back(e);
    end
    if (hen && hidx < 7'(N)) m[hidx[3:0]] = hd;
    if (rv) begin
      if (idx < 7'(N)) begin
        if (rw) begin
          if (RO[idx]) drop = 1'b1;
          else begin
            m[idx[3:0]]  = d;
            ep[idx[3:0]] = 1'b1;
          end
        end
      end else begin
`ifdef AOS_SR_RESP_ERRCNT_EN
        if (idx == 7'd127) begin
          if (rw) m_err = '0;
        end else drop = 1'b1;
`else
        drop = 1'b1;
`endif
      end
      if (drop && m_err != 32'hFFFF_FFFF) m_err = m_err + 32'd1;
    end
    @(negedge clk);
    idle_inputs();
    check_regs();
    chk("wr_pulse", 64'(wr_pulse_o), 64'(ep));
  endtask

  task automatic nop(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 16'h0, 64'h0, 1'b0, 7'h0, 64'h0);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    for (int i = 0; i < N; i++) m[i] = '0;
    m_err = '0;
    repeat (3) @(negedge clk);
    check_regs();
    chk("rst_wr_pulse", 64'(wr_pulse_o), 64'd0);
    chk("rst_resp_valid", {63'b0, sr_resp_valid_o}, 64'd0);
    chk("rst_resp_data", sr_resp_data_o, 64'd0);
    rst = 1'b0;

    // Basic write, one-cycle pulse, read-back
    step(1'b1, 1'b1, a(7'd3), 64'h0123_4567_89AB_CDEF, 1'b0, 7'd0, 64'h0);
    nop(1);
    step(1'b1, 1'b0, a(7'd3), 64'h0, 1'b0, 7'd0, 64'h0);
    nop(2);

    // Load reg[i] = i via hardware port, then back-to-back reads with ignored address bits set
    for (int i = 0; i < N; i++) step(1'b0, 1'b0, 16'h0, 64'h0, 1'b1, 7'(i), 64'(i));
    for (int i = 0; i < N; i++) step(1'b1, 1'b0, {6'h3F, 7'(i), 3'(i)}, 64'h0, 1'b0, 7'd0, 64'h0);
    nop(2);

    // Read-only register: host write dropped, hardware write lands
    step(1'b1, 1'b1, a(7'd2), 64'hFF, 1'b0, 7'd0, 64'h0);
    step(1'b0, 1'b0, 16'h0, 64'h0, 1'b1, 7'd2, 64'h55);

    // Collisions: same index host wins, different indices both commit
    step(1'b1, 1'b1, a(7'd5), 64'hA, 1'b1, 7'd5, 64'hB);
    step(1'b1, 1'b1, a(7'd5), 64'hD, 1'b1, 7'd6, 64'hC);

    // Read after host write sees new value; read alongside hardware write sees old value
    step(1'b1, 1'b1, a(7'd7), 64'h7777_0000_7777_0000, 1'b0, 7'd0, 64'h0);
    step(1'b1, 1'b0, a(7'd7), 64'h0, 1'b0, 7'd0, 64'h0);
    step(1'b1, 1'b0, a(7'd8), 64'h0, 1'b1, 7'd8, 64'h8888_8888_8888_8888);
    step(1'b1, 1'b0, a(7'd8), 64'h0, 1'b0, 7'd0, 64'h0);

    // Out-of-range read, write and hardware write
    step(1'b1, 1'b0, 16'h00A0, 64'h0, 1'b0, 7'd0, 64'h0);
    step(1'b1, 1'b1, 16'h00A0, 64'h1234, 1'b0, 7'd0, 64'h0);
    step(1'b0, 1'b0, 16'h0, 64'h0, 1'b1, 7'd100, 64'h99);
    nop(3);
    chk("resp_data_hold", sr_resp_data_o, OOR);

    // idx 127: counter when enabled, otherwise out-of-range
    step(1'b1, 1'b0, 16'h03F8, 64'h0, 1'b0, 7'd0, 64'h0);
    step(1'b1, 1'b1, 16'h03F8, 64'h5, 1'b0, 7'd0, 64'h0);
    step(1'b1, 1'b0, 16'h03F8, 64'h0, 1'b0, 7'd0, 64'h0);
    nop(2);

    // Reset while a read is in flight
    step(1'b1, 1'b0, a(7'd3), 64'h0, 1'b0, 7'd0, 64'h0);
    rst = 1'b1;
    sb.delete();
    for (int i = 0; i < N; i++) m[i] = '0;
    m_err = '0;
    @(negedge clk);
    chk("rst_inflight_valid_n2", {63'b0, sr_resp_valid_o}, 64'd0);
    chk("rst_inflight_data", sr_resp_data_o, 64'd0);
    check_regs();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_inflight_valid_n3", {63'b0, sr_resp_valid_o}, 64'd0);

    // Recovery after reset
    step(1'b1, 1'b1, a(7'd1), 64'hCAFE_F00D_0000_0001, 1'b0, 7'd0, 64'h0);
    step(1'b1, 1'b0, a(7'd1), 64'h0, 1'b0, 7'd0, 64'h0);
    nop(3);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
